// File: rtl/gray_to_binary_tracker.sv
// Gray-coded count receiver: synchronizes G, decodes it to binary and flags
// each change as an up-step, down-step or illegal multi-bit jump.
module gray_to_binary_tracker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     G,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     B,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 wrap,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    logic [WIDTH-1:0]     g_sync_p0 [SYNC_STAGES];
    logic [WIDTH-1:0]     g_prev_p1;
    logic [WIDTH-1:0]     g_s;
    logic [WIDTH-1:0]     b_s;
    logic [WIDTH-1:0]     g_diff;
    logic [WIDTH-1:0]     b_delta;
    logic                 one_flip;
    logic                 multi_flip;
    logic                 up_d;
    logic                 dn_d;
    logic                 wrap_d;
    logic [ERR_CNT_W-1:0] cnt_base;

    // Stage p0: synchronizer chain on the asynchronous Gray input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                g_sync_p0[i] <= '0;
            end
        end else begin
            g_sync_p0[0] <= G;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                g_sync_p0[i] <= g_sync_p0[i-1];
            end
        end
    end

    // B always equals gray2bin(g_prev_p1), so it serves as the previous binary value
    always_comb begin
        g_s        = g_sync_p0[SYNC_STAGES-1];
        b_s        = gray2bin(g_s);
        g_diff     = g_s ^ g_prev_p1;
        one_flip   = (g_diff != '0) && ((g_diff & (g_diff - WIDTH'(1))) == '0);
        multi_flip = (g_diff != '0) && !one_flip;
        b_delta    = b_s - B;
        up_d       = one_flip && (b_delta == WIDTH'(1));
        dn_d       = one_flip && (b_delta == '1);
        wrap_d     = (up_d && (&B)) || (dn_d && (B == '0));
        cnt_base   = clr_err ? '0 : err_cnt;
    end

    // Stage p1: decoded value, classification pulses and error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev_p1 <= '0;
            B         <= '0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            g_prev_p1 <= g_s;
            B         <= b_s;
            step_up   <= up_d;
            step_dn   <= dn_d;
            wrap      <= wrap_d;
            err       <= multi_flip;
            err_cnt   <= multi_flip ? sat_inc(cnt_base) : cnt_base;
        end
    end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Bench for gray_to_binary_tracker: directed vector table, multi-cycle corner
// sequences and randomized traffic against a sample-history reference model.
module tb_gray_to_binary_tracker;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int CW = 8;
    localparam int VW = W + 4 + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  G = 4'b0110;
    logic          clr_err = 1'b0;
    logic [W-1:0]  B;
    logic          step_up, step_dn, wrap, err;
    logic [CW-1:0] err_cnt;

    gray_to_binary_tracker #(.WIDTH(W), .SYNC_STAGES(SS), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .G(G), .clr_err(clr_err), .B(B),
        .step_up(step_up), .step_dn(step_dn), .wrap(wrap), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of G as sampled at each clock edge
    int hist[$];
    int m_b, m_cnt;
    bit m_up, m_dn, m_wrap, m_err;

    typedef struct {
        logic [W-1:0]  g;
        logic [W-1:0]  b;
        logic          up, dn, wr, er;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t tbl[24];

    function automatic int g2b(int g);
        int b = 0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b & ((1 << W) - 1);
    endfunction

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    function automatic vec_t mk(int g, int b, bit up, bit dn, bit wr, bit er, int cnt);
        vec_t v;
        v.g = W'(g); v.b = W'(b); v.up = up; v.dn = dn; v.wr = wr; v.er = er; v.cnt = CW'(cnt);
        return v;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {B, step_up, step_dn, wrap, err, err_cnt};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {W'(m_b), m_up, m_dn, m_wrap, m_err, CW'(m_cnt)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back(0);
        m_b = 0; m_cnt = 0; m_up = 0; m_dn = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int gs, gp, bs, bp, d, delta;
        hist.push_front(int'(G));
        void'(hist.pop_back());
        gs = hist[SS];
        gp = hist[SS+1];
        bs = g2b(gs);
        bp = g2b(gp);
        d = $countones(gs ^ gp);
        delta = (bs - bp + (1 << W)) % (1 << W);
        m_b    = bs;
        m_up   = (d == 1) && (delta == 1);
        m_dn   = (d == 1) && (delta == (1 << W) - 1);
        m_wrap = (m_up && bp == (1 << W) - 1) || (m_dn && bp == 0);
        m_err  = (d >= 2);
        if (clr_err) m_cnt = 0;
        if (m_err && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic cyc(input int g, input bit clr);
        @(negedge clk);
        G = W'(g);
        clr_err = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("cycle", 32'(dut_vec()), 32'(model_vec()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, cb, hold;
        vec_t v;

        for (int i = 1; i <= 16; i++) tbl[i-1] = mk(b2g(i % 16), i % 16, 1, 0, (i == 16), 0, 0);
        tbl[16] = mk(4'b0001, 1,  1, 0, 0, 0, 0);
        tbl[17] = mk(4'b0011, 2,  1, 0, 0, 0, 0);
        tbl[18] = mk(4'b0001, 1,  0, 1, 0, 0, 0);
        tbl[19] = mk(4'b0000, 0,  0, 1, 0, 0, 0);
        tbl[20] = mk(4'b1000, 15, 0, 1, 1, 0, 0);
        tbl[21] = mk(4'b0000, 0,  1, 0, 1, 0, 0);
        tbl[22] = mk(4'b0011, 2,  0, 0, 0, 1, 1);
        tbl[23] = mk(4'b0000, 0,  0, 0, 0, 1, 2);

        // Reset with a nonzero input, then release and step once
        model_reset();
        cyc(4'b0110, 0);
        cyc(4'b0110, 0);
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        #1;
        rst_n = 1'b1;
        G = 4'b0000;
        for (int i = 0; i < 3; i++) cyc(4'b0000, 0);
        check("idle_B", 32'(B), 32'h0);
        for (int i = 0; i < 3; i++) cyc(4'b0001, 0);
        check("latency_B", 32'(B), 32'h1);
        check("latency_up", 32'(step_up), 32'h1);
        cyc(4'b0001, 0);
        check("up_one_cycle", 32'(step_up), 32'h0);
        cyc(4'b0000, 0);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 0);

        // Table: up walk with wrap, down walk with wrap, illegal jumps
        for (int i = 0; i < 24; i++) begin
            v = tbl[i];
            for (int k = 0; k < 3; k++) cyc(int'(v.g), 0);
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({v.b, v.up, v.dn, v.wr, v.er, v.cnt}));
            cyc(int'(v.g), 0);
        end

        // Saturation, coincident clear+err, plain clear
        for (int k = 1; k <= 300; k++) cyc((k % 2) ? 4'b0011 : 4'b0000, 0);
        for (int i = 0; i < 3; i++) cyc(4'b0000, 0);
        check("sat_cnt", 32'(err_cnt), 32'd255);
        cyc(4'b0011, 0);
        cyc(4'b0011, 0);
        cyc(4'b0011, 1);
        check("clr_with_err_cnt", 32'(err_cnt), 32'd1);
        check("clr_with_err_err", 32'(err), 32'd1);
        cyc(4'b0011, 0);
        cyc(4'b0011, 1);
        check("clr_cnt", 32'(err_cnt), 32'd0);

        // Async reset mid-run with B=5 and err_cnt=7
        for (int k = 1; k <= 7; k++) cyc((k % 2) ? 4'b0000 : 4'b0011, 0);
        cyc(4'b0001, 0); cyc(4'b0011, 0); cyc(4'b0010, 0); cyc(4'b0110, 0);
        for (int i = 0; i < 4; i++) cyc(4'b0111, 0);
        check("pre_reset_B", 32'(B), 32'h5);
        check("pre_reset_cnt", 32'(err_cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", 32'(dut_vec()), 32'h0);
        cyc(4'b0111, 0);
        cyc(4'b0111, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(4'b0111, 0);
        check("post_reset_B", 32'(B), 32'h5);
        check("post_reset_err", 32'(err), 32'h1);
        check("post_reset_cnt", 32'(err_cnt), 32'h1);

        // Randomized traffic against the model
        for (int it = 0; it < 700; it++) begin
            cb = g2b(int'(G));
            g = $urandom_range(0, 99);
            if (g < 35)      g = b2g((cb + 1) % 16);
            else if (g < 65) g = b2g((cb + 15) % 16);
            else if (g < 85) g = $urandom_range(0, 15);
            else             g = int'(G);
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) cyc(g, ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
- Receiving end of our Gray-coded count path. Takes a Gray-coded counter value (e.g. a pointer from an asynchronous or free-running source) through a configurable synchronizer.
- Decodes the value to binary in a registered pipeline. Classifies each change as up-step, down-step or illegal (more than one bit flipped), and keeps a saturating error count.
- Sits downstream of the binary-to-Gray encoder in FIFO-pointer and encoder-position paths.

Parameters:
WIDTH, 4, bit width of the Gray input and binary output (2..16)
SYNC_STAGES, 2, number of synchronizer flops on G (1..4)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
G  input  WIDTH  Gray-coded input value, may change asynchronously
clr_err  input  1  synchronous clear of err_cnt
B  output  WIDTH  decoded binary value (registered)
step_up  output  1  one-cycle pulse: value advanced by +1 (mod 2^WIDTH)
step_dn  output  1  one-cycle pulse: value moved by -1 (mod 2^WIDTH)
wrap  output  1  one-cycle pulse: up-step from all-ones to 0, or down-step from 0 to all-ones
err  output  1  one-cycle pulse: more than one Gray bit changed between consecutive synced samples
err_cnt  output  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset (rst_n low, async): all sync flops, g_prev, B, step_up, step_dn, wrap, err and err_cnt go to 0 immediately. Outputs hold 0 until the first clock after release.
- Sync chain: G passes through SYNC_STAGES flops. g_s is the last flop output.
- Decode: b_s = gray2bin(g_s), with b_s[WIDTH-1] = g_s[WIDTH-1] and b_s[i] = b_s[i+1] XOR g_s[i]. Decode is combinational inside the stage.
- Each clock: B <= b_s; g_prev <= g_s; b_prev is B.
- Latency: a stable change on G appears on B exactly SYNC_STAGES+1 clocks later. The flags for that change are valid in the same cycle as B.
- Classification, registered in the same edge as B, using d = popcount(g_s XOR g_prev):
  - d=0: all pulses 0.
  - d=1 and (b_s - b_prev) mod 2^WIDTH = 1: step_up=1. wrap=1 if b_prev = 2^WIDTH-1.
  - d=1 and difference = 2^WIDTH-1: step_dn=1. wrap=1 if b_prev = 0.
  - d>=2: err=1; step_up=step_dn=wrap=0.
  - step_up, step_dn and err are mutually exclusive. Every pulse lasts exactly one cycle unless the next change also qualifies.
- B always tracks b_s, including on err cycles. There is no hold or correction.
- err_cnt:
  - Increments on err, saturates at 2^ERR_CNT_W-1; no wrap.
  - clr_err sets it to 0.
  - clr_err and err in the same cycle: err_cnt = 1. Clear applies first, then the increment.
- First sample after reset compares against g_prev = 0. A nonzero G already present at reset release is classified like any other change.
- Reset mid-operation: all state clears asynchronously. Pulses in flight are lost. err_cnt returns to 0.
- Back-to-back changes every clock are allowed; each is classified independently.

Test Plan (WIDTH=4, SYNC_STAGES=2, ERR_CNT_W=8):
1. Reset and latency:
   - Assert rst_n=0 with G=0110 -> all outputs 0 during reset.
   - Release, hold G=0000 -> B=0, no pulses.
   - Change G to 0001 at cycle t -> B=0001 and step_up=1 at t+3 for exactly one cycle.
2. Up walk with wrap:
   - Drive Gray sequence 0000,0001,0011,0010,0110,...,1000,0000, each held 4 clocks -> B steps 0..15,0; one step_up per change.
   - Going 1000->0000: B goes 15->0 with wrap=1 and step_up=1.
   - err_cnt stays 0.
3. Down walk with wrap:
   - G 0011->0001->0000->1000 -> B 2->1->0->15; step_dn on each change.
   - wrap=1 only on the 0->15 transition.
4. Illegal jump:
   - G 0000->0011 -> B=0010, err=1, step_up=step_dn=0, err_cnt=1.
   - Then 0011->0000 -> err_cnt=2.
5. Saturation and clear:
   - Toggle G 0000<->0011 for 300 changes -> err_cnt stops at 255.
   - Pulse clr_err -> 0.
   - clr_err coincident with an err pulse -> err_cnt=1.
6. Async reset mid-run:
   - Drop rst_n between clock edges while B=0101 and err_cnt=7 -> all outputs 0 before the next edge.
   - After release with G=0111 held -> B=0101 after 3 clocks; err=1, since d=3 versus g_prev=0.
